// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with a circular return-address stack.
// Priority jump > call > ret > branch > increment; en=0 freezes everything but clr_err.
module pc_stack_unit #(
  parameter int unsigned     PC_W      = 8,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter bit              WRAP_MODE = 1'b0,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            jump,
  input  logic            call,
  input  logic            ret,
  input  logic            branch,
  input  logic [PC_W-1:0] imm,
  input  logic            clr_err,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    CMD_INC,
    CMD_JUMP,
    CMD_CALL,
    CMD_RET,
    CMD_BRANCH
  } cmd_e;

  cmd_e             cmd;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             push;

  always_comb begin
    cmd = CMD_INC;
    if (jump)        cmd = CMD_JUMP;
    else if (call)   cmd = CMD_CALL;
    else if (ret)    cmd = CMD_RET;
    else if (branch) cmd = CMD_BRANCH;
  end

  // ptr_q is the next write slot; when full it also addresses the oldest entry,
  // so a push while full overwrites exactly that entry.
  always_comb begin
    ptr_inc = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
    ptr_dec = (ptr_q == '0) ? PTR_MAX : ptr_q - 1'b1;
    if (pc_q == '1) pc_inc = WRAP_MODE ? '0 : pc_q;
    else            pc_inc = pc_q + 1'b1;
  end

  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    push  = 1'b0;
    if (en) begin
      unique case (cmd)
        CMD_JUMP: pc_d = imm;
        CMD_CALL: begin
          push  = 1'b1;
          pc_d  = imm;
          ptr_d = ptr_inc;
          if (cnt_q == CNT_FULL) ovf_d = 1'b1;
          else                   cnt_d = cnt_q + 1'b1;
        end
        CMD_RET: begin
          if (cnt_q == '0) begin
            pc_d  = pc_inc;
            udf_d = 1'b1;
          end else begin
            pc_d  = ras_q[ptr_dec];
            ptr_d = ptr_dec;
            cnt_d = cnt_q - 1'b1;
          end
        end
        CMD_BRANCH: pc_d = pc_q + imm + 1'b1;
        default:    pc_d = pc_inc;
      endcase
    end
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_q[ptr_q] <= pc_q + 1'b1;
  end

  assign pc            = pc_q;
  assign pc_next       = pc_d;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == CNT_FULL);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = udf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: a saturating and a wrapping instance share stimulus.
module tb_pc_stack_unit;

  logic       clk = 1'b0;
  logic       rst_n, en, jump, call, ret, branch, clr_err;
  logic [7:0] imm;
  logic [7:0] pc0, pcn0, pc1, pcn1;
  logic       e0, f0, o0, u0, e1, f1, o1, u1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  pc_stack_unit #(.PC_W(8), .RAS_DEPTH(4), .WRAP_MODE(1'b0), .RESET_PC(8'h00)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .jump(jump), .call(call), .ret(ret),
    .branch(branch), .imm(imm), .clr_err(clr_err), .pc(pc0), .pc_next(pcn0),
    .ras_empty(e0), .ras_full(f0), .ras_overflow(o0), .ras_underflow(u0)
  );

  pc_stack_unit #(.PC_W(8), .RAS_DEPTH(4), .WRAP_MODE(1'b1), .RESET_PC(8'h00)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .jump(jump), .call(call), .ret(ret),
    .branch(branch), .imm(imm), .clr_err(clr_err), .pc(pc1), .pc_next(pcn1),
    .ras_empty(e1), .ras_full(f1), .ras_overflow(o1), .ras_underflow(u1)
  );

  task automatic idle();
    en = 1'b1; jump = 1'b0; call = 1'b0; ret = 1'b0; branch = 1'b0;
    clr_err = 1'b0; imm = 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #1;
    checks++; if (pc0 !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc0); end
    checks++; if ({e0, f0, o0, u0} !== 4'b1000) begin errors++; $display("FAIL reset_flags got %b exp 1000", {e0, f0, o0, u0}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (pcn0 !== 8'h01) begin errors++; $display("FAIL reset_pcnext got %h exp 01", pcn0); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pc0 !== 8'(i)) begin errors++; $display("FAIL idle_pc%0d got %h exp %h", i, pc0, 8'(i)); end
    end
    checks++; if ({e0, o0, u0} !== 3'b100) begin errors++; $display("FAIL idle_flags got %b exp 100", {e0, o0, u0}); end
  endtask

  task automatic test_call_ret();
    jump = 1'b1; imm = 8'h10; step(); jump = 1'b0;
    checks++; if (pc0 !== 8'h10) begin errors++; $display("FAIL jump_pc got %h exp 10", pc0); end
    call = 1'b1; imm = 8'h40; #1;
    checks++; if (pcn0 !== 8'h40) begin errors++; $display("FAIL call_pcnext got %h exp 40", pcn0); end
    step(); call = 1'b0;
    checks++; if (pc0 !== 8'h40 || e0 !== 1'b0) begin errors++; $display("FAIL call1 got pc %h empty %b exp 40 0", pc0, e0); end
    step();
    checks++; if (pc0 !== 8'h41) begin errors++; $display("FAIL inc_after_call got %h exp 41", pc0); end
    call = 1'b1; imm = 8'h80; step(); call = 1'b0;
    checks++; if (pc0 !== 8'h80) begin errors++; $display("FAIL call2 got %h exp 80", pc0); end
    ret = 1'b1; step(); ret = 1'b0;
    checks++; if (pc0 !== 8'h42) begin errors++; $display("FAIL ret1 got %h exp 42", pc0); end
    ret = 1'b1; step(); ret = 1'b0;
    checks++; if (pc0 !== 8'h11 || e0 !== 1'b1) begin errors++; $display("FAIL ret2 got pc %h empty %b exp 11 1", pc0, e0); end
  endtask

  task automatic test_overflow();
    logic [7:0] tgt [5];
    logic [7:0] ra  [5];
    tgt = '{8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
    ra  = '{8'h12, 8'h51, 8'h61, 8'h71, 8'h81};
    for (int i = 0; i < 5; i++) begin
      call = 1'b1; imm = tgt[i]; step(); call = 1'b0;
      checks++; if (pc0 !== tgt[i]) begin errors++; $display("FAIL ovf_call%0d got %h exp %h", i, pc0, tgt[i]); end
      if (i == 3) begin
        checks++; if ({f0, o0} !== 2'b10) begin errors++; $display("FAIL full4 got full,ovf %b exp 10", {f0, o0}); end
      end
    end
    checks++; if ({f0, o0} !== 2'b11) begin errors++; $display("FAIL full5 got full,ovf %b exp 11", {f0, o0}); end
    for (int i = 0; i < 4; i++) begin
      ret = 1'b1; step(); ret = 1'b0;
      checks++; if (pc0 !== ra[4-i]) begin errors++; $display("FAIL ovf_ret%0d got %h exp %h", i, pc0, ra[4-i]); end
    end
    checks++; if ({e0, u0} !== 2'b10) begin errors++; $display("FAIL drained got empty,udf %b exp 10", {e0, u0}); end
    ret = 1'b1; step(); ret = 1'b0;
    checks++; if (pc0 !== 8'h52) begin errors++; $display("FAIL udf_ret_pc got %h exp 52", pc0); end
    checks++; if ({o0, u0} !== 2'b11) begin errors++; $display("FAIL udf_flags got ovf,udf %b exp 11", {o0, u0}); end
  endtask

  task automatic test_clr_err();
    en = 1'b0; clr_err = 1'b1; step(); clr_err = 1'b0;
    checks++; if ({o0, u0} !== 2'b00 || pc0 !== 8'h52) begin errors++; $display("FAIL clr_stalled got flags %b pc %h exp 00 52", {o0, u0}, pc0); end
    en = 1'b1; ret = 1'b1; clr_err = 1'b1; step(); clr_err = 1'b0; ret = 1'b0;
    checks++; if (u0 !== 1'b0 || pc0 !== 8'h53) begin errors++; $display("FAIL clr_priority got udf %b pc %h exp 0 53", u0, pc0); end
    ret = 1'b1; step(); ret = 1'b0;
    checks++; if (u0 !== 1'b1 || pc0 !== 8'h54) begin errors++; $display("FAIL udf_again got udf %b pc %h exp 1 54", u0, pc0); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_sat [3];
    logic [7:0] exp_wrp [3];
    exp_sat = '{8'hFF, 8'hFF, 8'hFF};
    exp_wrp = '{8'hFF, 8'h00, 8'h01};
    jump = 1'b1; imm = 8'hFE; step(); jump = 1'b0;
    checks++; if (pc0 !== 8'hFE || pc1 !== 8'hFE) begin errors++; $display("FAIL wrap_start got %h %h exp FE FE", pc0, pc1); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc0 !== exp_sat[i]) begin errors++; $display("FAIL sat%0d got %h exp %h", i, pc0, exp_sat[i]); end
      checks++; if (pc1 !== exp_wrp[i]) begin errors++; $display("FAIL wrap%0d got %h exp %h", i, pc1, exp_wrp[i]); end
    end
    checks++; if (pcn0 !== 8'hFF) begin errors++; $display("FAIL sat_pcnext got %h exp FF", pcn0); end
  endtask

  task automatic test_branch_priority();
    jump = 1'b1; imm = 8'h20; step(); jump = 1'b0;
    branch = 1'b1; imm = 8'hFB; step();
    checks++; if (pc0 !== 8'h1C) begin errors++; $display("FAIL branch_back got %h exp 1C", pc0); end
    imm = 8'hFF; step(); branch = 1'b0;
    checks++; if (pc0 !== 8'h1C) begin errors++; $display("FAIL branch_self got %h exp 1C", pc0); end
    jump = 1'b1; imm = 8'hFF; step(); jump = 1'b0;
    branch = 1'b1; imm = 8'h00; step(); branch = 1'b0;
    checks++; if (pc0 !== 8'h00) begin errors++; $display("FAIL branch_nosat got %h exp 00", pc0); end
    call = 1'b1; imm = 8'h30; step(); call = 1'b0;
    checks++; if (pc0 !== 8'h30) begin errors++; $display("FAIL prio_setup got %h exp 30", pc0); end
    jump = 1'b1; call = 1'b1; branch = 1'b1; imm = 8'h33; step();
    jump = 1'b0; call = 1'b0; branch = 1'b0;
    checks++; if (pc0 !== 8'h33 || {e0, f0} !== 2'b00) begin errors++; $display("FAIL prio_jump got pc %h empty,full %b exp 33 00", pc0, {e0, f0}); end
    ret = 1'b1; branch = 1'b1; imm = 8'h05; step(); ret = 1'b0; branch = 1'b0;
    checks++; if (pc0 !== 8'h01 || e0 !== 1'b1) begin errors++; $display("FAIL prio_ret got pc %h empty %b exp 01 1", pc0, e0); end
  endtask

  task automatic test_stall_reset();
    jump = 1'b1; imm = 8'h45; step(); jump = 1'b0;
    call = 1'b1; imm = 8'h60; step();
    en = 1'b0; imm = 8'h77; #1;
    checks++; if (pcn0 !== 8'h60) begin errors++; $display("FAIL stall_pcnext got %h exp 60", pcn0); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (pc0 !== 8'h60 || e0 !== 1'b0) begin errors++; $display("FAIL stall%0d got pc %h empty %b exp 60 0", i, pc0, e0); end
    end
    en = 1'b1; call = 1'b0; ret = 1'b1; step(); ret = 1'b0;
    checks++; if (pc0 !== 8'h46 || e0 !== 1'b1) begin errors++; $display("FAIL stall_count got pc %h empty %b exp 46 1", pc0, e0); end
    call = 1'b1; imm = 8'h60; step();
    en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (pc0 !== 8'h00) begin errors++; $display("FAIL async_reset_pc got %h exp 00", pc0); end
    checks++; if ({e0, f0, o0, u0} !== 4'b1000) begin errors++; $display("FAIL async_reset_flags got %b exp 1000", {e0, f0, o0, u0}); end
    #1 rst_n = 1'b1;
    idle();
    step();
    checks++; if (pc0 !== 8'h01) begin errors++; $display("FAIL post_reset got %h exp 01", pc0); end
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_overflow();
    test_clr_err();
    test_wrap();
    test_branch_priority();
    test_stall_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
